// File: rtl/ccu_pkg.sv
// Shared types for the CCU transaction sequencer: FSM encoding and default ACE channel structs.
package ccu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RDATA = 3'd4
  } seq_state_e;

  // Port index for the default two-master build; other widths are derived locally from NoPorts.
  localparam int unsigned DefaultNoPorts = 2;
  typedef logic [$clog2(DefaultNoPorts)-1:0] idx_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ace_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } ace_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } ace_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } ace_r_t;

  typedef struct packed {
    ace_ax_t     aw;
    logic        aw_valid;
    ace_w_t      w;
    logic        w_valid;
    logic        b_ready;
    ace_ax_t     ar;
    logic        ar_valid;
    logic        r_ready;
    logic        ac_ready;
    logic        cr_valid;
    logic [4:0]  cr_resp;
    logic        cd_valid;
    logic [31:0] cd_data;
    logic        cd_last;
  } ace_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    ace_b_t      b;
    logic        r_valid;
    ace_r_t      r;
    logic        ac_valid;
    logic [31:0] ac_addr;
    logic [3:0]  ac_snoop;
    logic        cr_ready;
    logic        cd_ready;
  } ace_resp_t;

endpackage

// File: rtl/ccu_rr_select.sv
// Combinational round-robin pick: first requesting port at or after rr_q, wrapping at NoPorts.
module ccu_rr_select
  import ccu_pkg::*;
#(
  parameter int unsigned  NoPorts = 2,
  localparam int unsigned IdxW    = $clog2(NoPorts)
) (
  input  logic [NoPorts-1:0] req,
  input  logic [IdxW-1:0]    rr_q,
  output logic [IdxW-1:0]    idx,
  output logic               any
);

  logic [31:0]     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    idx      = rr_q;
    any      = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NoPorts; i++) begin
      cand     = (32'(rr_q) + i) % NoPorts;
      cand_idx = IdxW'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ccu_txn_sequencer.sv
// Serialises AW/AR transactions from NoPorts cache masters onto one CCU port, one in flight,
// with the granted port locked until its B or last R completes.
//
// state | meaning
// IDLE  | nothing in flight; round-robin pick among ports with aw_valid|ar_valid
// ADDR  | locked port's AW or AR forwarded until the downstream handshake
// WDATA | locked port's W beats forwarded until the w.last handshake
// WRESP | B routed back to the locked port until its handshake
// RDATA | R beats routed back to the locked port until the r.last handshake
module ccu_txn_sequencer
  import ccu_pkg::*;
#(
  parameter int unsigned  NoPorts    = 2,
  parameter logic         WriteFirst = 1'b1,
  parameter type          req_t      = ace_req_t,
  parameter type          resp_t     = ace_resp_t,
  localparam int unsigned IdxW       = $clog2(NoPorts)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  req_t            core_req_i  [NoPorts],
  output resp_t           core_resp_o [NoPorts],
  output req_t            ccu_req_o,
  input  resp_t           ccu_resp_i,
  output logic            busy_o,
  output logic [IdxW-1:0] sel_idx_o
);

  seq_state_e         state_q, state_d;
  logic [IdxW-1:0]    sel_q, sel_d, rr_q, rr_d, pick_idx, sel_inc;
  logic               is_wr_q, is_wr_d, pick_any;
  logic [NoPorts-1:0] req_vec;
  req_t               sel_req, pick_req;
  logic               unused_snoop;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NoPorts; i++) begin
      req_vec[i] = core_req_i[i].aw_valid | core_req_i[i].ar_valid;
    end
  end

  ccu_rr_select #(.NoPorts(NoPorts)) u_rr_select (
    .req  (req_vec),
    .rr_q (rr_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign sel_req   = core_req_i[sel_q];
  assign pick_req  = core_req_i[pick_idx];
  assign sel_inc   = (sel_q == IdxW'(NoPorts - 1)) ? '0 : sel_q + 1'b1;
  assign busy_o    = (state_q != IDLE);
  assign sel_idx_o = sel_q;

  // Snoop traffic is not serviced; its inputs are deliberately ignored.
  always_comb begin
    unused_snoop = ccu_resp_i.ac_valid ^ (^ccu_resp_i.ac_addr) ^ (^ccu_resp_i.ac_snoop);
    for (int i = 0; i < NoPorts; i++) begin
      unused_snoop ^= core_req_i[i].ac_ready ^ core_req_i[i].cr_valid ^ (^core_req_i[i].cr_resp)
                    ^ core_req_i[i].cd_valid ^ (^core_req_i[i].cd_data) ^ core_req_i[i].cd_last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      is_wr_q <= is_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    is_wr_d   = is_wr_q;
    ccu_req_o = '0;
    for (int i = 0; i < NoPorts; i++) begin
      core_resp_o[i] = '0;
    end

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          is_wr_d = (pick_req.aw_valid && pick_req.ar_valid) ? WriteFirst : pick_req.aw_valid;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (is_wr_q) begin
          ccu_req_o.aw                = sel_req.aw;
          ccu_req_o.aw_valid          = sel_req.aw_valid;
          core_resp_o[sel_q].aw_ready = ccu_resp_i.aw_ready;
          if (sel_req.aw_valid && ccu_resp_i.aw_ready) state_d = WDATA;
        end else begin
          ccu_req_o.ar                = sel_req.ar;
          ccu_req_o.ar_valid          = sel_req.ar_valid;
          core_resp_o[sel_q].ar_ready = ccu_resp_i.ar_ready;
          if (sel_req.ar_valid && ccu_resp_i.ar_ready) state_d = RDATA;
        end
      end
      WDATA: begin
        ccu_req_o.w                = sel_req.w;
        ccu_req_o.w_valid          = sel_req.w_valid;
        core_resp_o[sel_q].w_ready = ccu_resp_i.w_ready;
        if (sel_req.w_valid && ccu_resp_i.w_ready && sel_req.w.last) state_d = WRESP;
      end
      WRESP: begin
        ccu_req_o.b_ready          = sel_req.b_ready;
        core_resp_o[sel_q].b       = ccu_resp_i.b;
        core_resp_o[sel_q].b_valid = ccu_resp_i.b_valid;
        if (ccu_resp_i.b_valid && sel_req.b_ready) begin
          state_d = IDLE;
          rr_d    = sel_inc;
        end
      end
      RDATA: begin
        ccu_req_o.r_ready          = sel_req.r_ready;
        core_resp_o[sel_q].r       = ccu_resp_i.r;
        core_resp_o[sel_q].r_valid = ccu_resp_i.r_valid;
        if (ccu_resp_i.r_valid && sel_req.r_ready && ccu_resp_i.r.last) begin
          state_d = IDLE;
          rr_d    = sel_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ccu_txn_sequencer.sv
// Directed self-checking bench for ccu_txn_sequencer (two ports, AW-first and AR-first builds).
module tb_ccu_txn_sequencer;
  import ccu_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_ni;
  ace_req_t  core_req  [2];
  ace_resp_t core_resp [2];
  ace_req_t  ccu_req;
  ace_resp_t ccu_resp;
  logic      busy;
  logic      sel_idx;

  ace_req_t  core_req_rf  [2];
  ace_resp_t core_resp_rf [2];
  ace_req_t  ccu_req_rf;
  ace_resp_t ccu_resp_rf;
  logic      busy_rf;
  logic      sel_idx_rf;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  ccu_txn_sequencer #(.NoPorts(2), .WriteFirst(1'b1), .req_t(ace_req_t), .resp_t(ace_resp_t)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .core_req_i  (core_req),
    .core_resp_o (core_resp),
    .ccu_req_o   (ccu_req),
    .ccu_resp_i  (ccu_resp),
    .busy_o      (busy),
    .sel_idx_o   (sel_idx)
  );

  ccu_txn_sequencer #(.NoPorts(2), .WriteFirst(1'b0), .req_t(ace_req_t), .resp_t(ace_resp_t)) dut_rf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .core_req_i  (core_req_rf),
    .core_resp_o (core_resp_rf),
    .ccu_req_o   (ccu_req_rf),
    .ccu_resp_i  (ccu_resp_rf),
    .busy_o      (busy_rf),
    .sel_idx_o   (sel_idx_rf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      core_req[i]    = '0;
      core_req_rf[i] = '0;
    end
    ccu_resp    = '0;
    ccu_resp_rf = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clr();
    settle();
    tick();
    rst_ni = 1'b1;
    settle();
  endtask

  initial begin
    rst_ni = 1'b0;
    clr();

    // T1: reset with port0 AW pending, then a single-beat write completes
    core_req[0].aw_valid = 1'b1;
    core_req[0].aw.addr  = 32'h100;
    core_req[0].aw.id    = 4'h1;
    ccu_resp.aw_ready    = 1'b1;
    tick(); settle();
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_awv", ccu_req.aw_valid, 0);
    chk("t1_rst_awrdy", core_resp[0].aw_ready, 0);
    tick(); rst_ni = 1'b1; settle();
    chk("t1_rel_awv", ccu_req.aw_valid, 0);
    chk("t1_rel_awrdy", core_resp[0].aw_ready, 0);
    tick(); settle();
    chk("t1_addr_awv", ccu_req.aw_valid, 1);
    chk("t1_addr_awaddr", ccu_req.aw.addr, 32'h100);
    chk("t1_addr_awrdy", core_resp[0].aw_ready, 1);
    chk("t1_addr_sel", sel_idx, 0);
    chk("t1_addr_busy", busy, 1);
    tick();
    core_req[0].aw_valid = 1'b0;
    core_req[0].w_valid  = 1'b1;
    core_req[0].w.data   = 32'hAAAA5555;
    core_req[0].w.last   = 1'b1;
    ccu_resp.w_ready     = 1'b1;
    settle();
    chk("t1_w_valid", ccu_req.w_valid, 1);
    chk("t1_w_data", ccu_req.w.data, 32'hAAAA5555);
    chk("t1_w_rdy0", core_resp[0].w_ready, 1);
    chk("t1_w_awv", ccu_req.aw_valid, 0);
    tick();
    core_req[0].w_valid = 1'b0;
    core_req[0].b_ready = 1'b1;
    ccu_resp.b_valid    = 1'b1;
    ccu_resp.b.id       = 4'h1;
    settle();
    chk("t1_b_valid0", core_resp[0].b_valid, 1);
    chk("t1_b_id0", core_resp[0].b.id, 4'h1);
    chk("t1_b_valid1", core_resp[1].b_valid, 0);
    chk("t1_b_ready", ccu_req.b_ready, 1);
    tick();
    ccu_resp.b_valid = 1'b0;
    settle();
    chk("t1_done_busy", busy, 0);
    // rr_q now points at port1: both requesting -> port1 wins
    core_req[0].ar_valid = 1'b1;
    core_req[1].ar_valid = 1'b1;
    tick(); settle();
    chk("t1_rr_sel", sel_idx, 1);

    // T2: both ports read, port0 first from reset, then port1, then back to port0
    do_reset();
    core_req[0].ar_valid = 1'b1;
    core_req[0].ar.addr  = 32'h200;
    core_req[0].ar.id    = 4'h1;
    core_req[0].r_ready  = 1'b1;
    core_req[1].ar_valid = 1'b1;
    core_req[1].ar.addr  = 32'h300;
    core_req[1].ar.id    = 4'h2;
    core_req[1].r_ready  = 1'b1;
    ccu_resp.ar_ready    = 1'b1;
    settle();
    chk("t2_c0_arv", ccu_req.ar_valid, 0);
    tick(); settle();
    chk("t2_c1_sel", sel_idx, 0);
    chk("t2_c1_arv", ccu_req.ar_valid, 1);
    chk("t2_c1_araddr", ccu_req.ar.addr, 32'h200);
    chk("t2_c1_arrdy0", core_resp[0].ar_ready, 1);
    chk("t2_c1_arrdy1", core_resp[1].ar_ready, 0);
    tick();
    core_req[0].ar_valid = 1'b0;
    ccu_resp.r_valid     = 1'b1;
    ccu_resp.r.id        = 4'h1;
    ccu_resp.r.data      = 32'h11;
    ccu_resp.r.last      = 1'b0;
    settle();
    chk("t2_r0_valid0", core_resp[0].r_valid, 1);
    chk("t2_r0_valid1", core_resp[1].r_valid, 0);
    chk("t2_r0_data", core_resp[0].r.data, 32'h11);
    tick();
    ccu_resp.r.data = 32'h22;
    ccu_resp.r.last = 1'b1;
    settle();
    chk("t2_r1_data", core_resp[0].r.data, 32'h22);
    chk("t2_r1_busy", busy, 1);
    tick();
    ccu_resp.r_valid = 1'b0;
    settle();
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_arv", ccu_req.ar_valid, 0);
    tick(); settle();
    chk("t2_p1_sel", sel_idx, 1);
    chk("t2_p1_araddr", ccu_req.ar.addr, 32'h300);
    chk("t2_p1_arrdy0", core_resp[0].ar_ready, 0);
    chk("t2_p1_arrdy1", core_resp[1].ar_ready, 1);
    tick();
    core_req[1].ar_valid = 1'b0;
    ccu_resp.r_valid     = 1'b1;
    ccu_resp.r.id        = 4'h2;
    ccu_resp.r.data      = 32'h33;
    ccu_resp.r.last      = 1'b1;
    settle();
    chk("t2_p1_rvalid1", core_resp[1].r_valid, 1);
    chk("t2_p1_rvalid0", core_resp[0].r_valid, 0);
    chk("t2_p1_rid", core_resp[1].r.id, 4'h2);
    tick();
    ccu_resp.r_valid     = 1'b0;
    core_req[0].ar_valid = 1'b1;
    core_req[1].ar_valid = 1'b1;
    settle();
    chk("t2_wrap_busy", busy, 0);
    tick(); settle();
    chk("t2_wrap_sel", sel_idx, 0);

    // T3: port1 burst write of 4 beats with W presented before the AW handshake
    do_reset();
    core_req[1].aw_valid = 1'b1;
    core_req[1].aw.addr  = 32'h500;
    core_req[1].aw.len   = 8'd3;
    core_req[1].w_valid  = 1'b1;
    core_req[1].w.data   = 32'h10;
    core_req[1].b_ready  = 1'b1;
    ccu_resp.w_ready     = 1'b1;
    tick(); settle();
    chk("t3_addr_sel", sel_idx, 1);
    chk("t3_addr_awlen", ccu_req.aw.len, 8'd3);
    chk("t3_addr_wrdy", core_resp[1].w_ready, 0);
    chk("t3_addr_wv", ccu_req.w_valid, 0);
    tick();
    ccu_resp.aw_ready = 1'b1;
    settle();
    chk("t3_hs_awrdy1", core_resp[1].aw_ready, 1);
    chk("t3_hs_wrdy", core_resp[1].w_ready, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      core_req[1].aw_valid = 1'b0;
      ccu_resp.aw_ready    = 1'b0;
      core_req[1].w.data   = 32'h10 + 32'(b);
      core_req[1].w.last   = (b == 3);
      settle();
      chk("t3_beat_data", ccu_req.w.data, 32'h10 + 32'(b));
      chk("t3_beat_wrdy1", core_resp[1].w_ready, 1);
      chk("t3_beat_wrdy0", core_resp[0].w_ready, 0);
      chk("t3_beat_bv0", core_resp[0].b_valid, 0);
    end
    tick();
    core_req[1].w_valid = 1'b0;
    ccu_resp.b_valid    = 1'b1;
    ccu_resp.b.id       = 4'h5;
    settle();
    chk("t3_b_valid1", core_resp[1].b_valid, 1);
    chk("t3_b_id1", core_resp[1].b.id, 4'h5);
    chk("t3_b_valid0", core_resp[0].b_valid, 0);
    tick();
    ccu_resp.b_valid = 1'b0;
    settle();
    chk("t3_done_busy", busy, 0);
    chk("t3_done_bv0", core_resp[0].b_valid, 0);

    // T4: port0 has AW and AR together; AW-first build vs AR-first build
    do_reset();
    core_req[0].aw_valid    = 1'b1;
    core_req[0].ar_valid    = 1'b1;
    core_req[0].ar.addr     = 32'h600;
    core_req[0].w_valid     = 1'b1;
    core_req[0].w.last      = 1'b1;
    core_req[0].b_ready     = 1'b1;
    ccu_resp.aw_ready       = 1'b1;
    ccu_resp.w_ready        = 1'b1;
    core_req_rf[0].aw_valid = 1'b1;
    core_req_rf[0].ar_valid = 1'b1;
    core_req_rf[0].r_ready  = 1'b1;
    ccu_resp_rf.ar_ready    = 1'b1;
    tick(); settle();
    chk("t4_wf_awv", ccu_req.aw_valid, 1);
    chk("t4_wf_arv", ccu_req.ar_valid, 0);
    chk("t4_wf_arrdy", core_resp[0].ar_ready, 0);
    chk("t4_rf_arv", ccu_req_rf.ar_valid, 1);
    chk("t4_rf_awv", ccu_req_rf.aw_valid, 0);
    tick();
    core_req[0].aw_valid    = 1'b0;
    core_req_rf[0].ar_valid = 1'b0;
    ccu_resp_rf.r_valid     = 1'b1;
    ccu_resp_rf.r.last      = 1'b1;
    settle();
    chk("t4_wf_wv", ccu_req.w_valid, 1);
    tick();
    core_req[0].w_valid = 1'b0;
    ccu_resp.b_valid    = 1'b1;
    ccu_resp_rf.r_valid = 1'b0;
    settle();
    chk("t4_rf_idle", busy_rf, 0);
    tick();
    ccu_resp.b_valid = 1'b0;
    settle();
    chk("t4_wf_idle", busy, 0);
    tick(); settle();
    chk("t4_wf_ar2", ccu_req.ar_valid, 1);
    chk("t4_wf_araddr", ccu_req.ar.addr, 32'h600);
    chk("t4_wf_aw2", ccu_req.aw_valid, 0);
    chk("t4_rf_aw2", ccu_req_rf.aw_valid, 1);

    // T5: downstream stalls AR for 10 cycles; port0 stays locked, port1 waits
    do_reset();
    core_req[0].ar_valid = 1'b1;
    core_req[0].ar.addr  = 32'h400;
    core_req[0].ar.id    = 4'h3;
    core_req[0].ar.len   = 8'd3;
    core_req[0].r_ready  = 1'b1;
    core_req[1].ar_valid = 1'b1;
    core_req[1].ar.addr  = 32'h700;
    tick();
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("t5_stall_arv", ccu_req.ar_valid, 1);
      chk("t5_stall_addr", ccu_req.ar.addr, 32'h400);
      chk("t5_stall_id", ccu_req.ar.id, 4'h3);
      chk("t5_stall_sel", sel_idx, 0);
      chk("t5_stall_rdy1", core_resp[1].ar_ready, 0);
      tick();
    end
    ccu_resp.ar_ready = 1'b1;
    settle();
    chk("t5_hs_rdy0", core_resp[0].ar_ready, 1);

    // T6: reset lands in RDATA after 2 of 4 beats; later beats never reach a core
    tick();
    core_req[0].ar_valid = 1'b0;
    ccu_resp.ar_ready    = 1'b0;
    ccu_resp.r_valid     = 1'b1;
    ccu_resp.r.data      = 32'hB0;
    settle();
    chk("t6_beat0", core_resp[0].r_valid, 1);
    tick();
    ccu_resp.r.data = 32'hB1;
    settle();
    chk("t6_beat1", core_resp[0].r_valid, 1);
    tick();
    ccu_resp.r.data      = 32'hB2;
    core_req[1].ar_valid = 1'b0;
    rst_ni               = 1'b0;
    settle();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rv0", core_resp[0].r_valid, 0);
    chk("t6_rst_rdata0", core_resp[0].r.data, 0);
    chk("t6_rst_rready", ccu_req.r_ready, 0);
    tick();
    rst_ni          = 1'b1;
    ccu_resp.r.data = 32'hB3;
    ccu_resp.r.last = 1'b1;
    settle();
    chk("t6_post_rv0", core_resp[0].r_valid, 0);
    chk("t6_post_rv1", core_resp[1].r_valid, 0);
    tick(); settle();
    chk("t6_post2_rv0", core_resp[0].r_valid, 0);
    chk("t6_post2_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
